// File: rtl/seg_scan_drv_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_drv_pkg
// Shared definitions for the multiplexed seven-segment scanner:
//   - default parameter values for the scanner and its blink divider
//   - clog2 helper used to size counters and index buses
//   - idle drive values for segments (SEG_OFF) and common enables (ENB_OFF)
//   - digit_cfg_t: one digit's frame-captured display state
// No ports (package).
// -----------------------------------------------------------------------------
package seg_scan_drv_pkg;

  localparam int DEF_NUM_DIGITS = 6;
  localparam int DEF_SCAN_DIV   = 5000;
  localparam int DEF_BLANK_CYC  = 50;
  localparam int DEF_BLINK_DIV  = 25000000;
  localparam int DEF_DIM_BITS   = 3;

  // Segments are active-high, so "off" is all zeros.
  localparam logic [6:0] SEG_OFF = 7'b0;
  // Common enables are active-low: an idle enable bit is driven high.
  // A fully idle enable bus is {NUM_DIGITS{ENB_OFF}}.
  localparam logic       ENB_OFF = 1'b1;

  // Per-digit state captured at frame start.
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic       blank;
    logic       blink;
  } digit_cfg_t;

  // Ceiling log2, never less than 1 so it can size a bus directly.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_drv_if.sv
// -----------------------------------------------------------------------------
// seg_scan_drv_if
// Bundles the digit-data inputs and the FND pin outputs of seg_scan_drv.
//   master : producer of digit data / consumer of pin drive (decoders, bench)
//   slave  : the scanner itself
// Signals:
//   i_digit_seg  [7*NUM_DIGITS] digit k segments at [7k+6:7k], a is MSB
//   i_dp         [NUM_DIGITS]   decimal point per digit
//   i_blank_mask [NUM_DIGITS]   1 = digit dark
//   i_blink_mask [NUM_DIGITS]   1 = digit blinks
//   i_dim        [DIM_BITS]     brightness, all-ones = full
//   o_seg        [7]            segment drive, active-high
//   o_seg_dp     [1]            decimal-point drive
//   o_seg_enb    [NUM_DIGITS]   common enables, active-low
//   o_digit_idx  [IDX_W]        digit currently scanned
//   o_frame_start[1]            one-cycle pulse at each frame start
// -----------------------------------------------------------------------------
interface seg_scan_drv_if
  import seg_scan_drv_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIM_BITS   = DEF_DIM_BITS
);
  localparam int IDX_W = clog2(NUM_DIGITS);

  logic [7*NUM_DIGITS-1:0] i_digit_seg;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic [NUM_DIGITS-1:0]   i_blank_mask;
  logic [NUM_DIGITS-1:0]   i_blink_mask;
  logic [DIM_BITS-1:0]     i_dim;
  logic [6:0]              o_seg;
  logic                    o_seg_dp;
  logic [NUM_DIGITS-1:0]   o_seg_enb;
  logic [IDX_W-1:0]        o_digit_idx;
  logic                    o_frame_start;

  modport master (
    output i_digit_seg, i_dp, i_blank_mask, i_blink_mask, i_dim,
    input  o_seg, o_seg_dp, o_seg_enb, o_digit_idx, o_frame_start
  );

  modport slave (
    input  i_digit_seg, i_dp, i_blank_mask, i_blink_mask, i_dim,
    output o_seg, o_seg_dp, o_seg_enb, o_digit_idx, o_frame_start
  );

endinterface

// File: rtl/seg_scan_drv_blink_div.sv
// -----------------------------------------------------------------------------
// seg_blink_div
// Free-running modulo-BLINK_DIV counter; o_phase toggles each time the
// counter wraps, giving a square wave of BLINK_DIV cycles per half-period.
// Phase resets to 1 so blinking digits start visible.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   o_phase out blink phase, 1 = visible half
// -----------------------------------------------------------------------------
module seg_blink_div
  import seg_scan_drv_pkg::*;
#(
  parameter int BLINK_DIV = DEF_BLINK_DIV
)(
  input  logic clk,
  input  logic rst_n,
  output logic o_phase
);

  localparam int CNT_W = clog2(BLINK_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(BLINK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      if (w_wrap) r_phase <= ~r_phase;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/seg_scan_drv.sv
// -----------------------------------------------------------------------------
// seg_scan_drv
// Multiplexed seven-segment scanner for NUM_DIGITS digits. Each digit gets a
// slot of SCAN_DIV cycles: BLANK_CYC dead cycles, then a lit window whose
// length follows i_dim (PWM dimming), then dark for the rest of the slot.
// Digit data and masks are captured once per frame so the display never
// shows a half-updated value. Blanked digits stay dark; blinking digits are
// dark during the off half of the blink divider.
// Ports:
//   clk    in  system clock (only clock; all timing by count enables)
//   rst_n  in  asynchronous active-low reset
//   bus    seg_scan_drv_if.slave  digit inputs and FND pin outputs
// -----------------------------------------------------------------------------
module seg_scan_drv
  import seg_scan_drv_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int BLANK_CYC  = DEF_BLANK_CYC,
  parameter int BLINK_DIV  = DEF_BLINK_DIV,
  parameter int DIM_BITS   = DEF_DIM_BITS
)(
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_drv_if.slave bus
);

  localparam int CNT_W = clog2(SCAN_DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int LEN_W = clog2(SCAN_DIV + 1);
  localparam logic [31:0] ON_SPAN = 32'(SCAN_DIV - BLANK_CYC);
  localparam logic [31:0] BLANK_U = 32'(BLANK_CYC);

  // ---------------------------------------------------------------------------
  // Slot / digit counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_slot_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             w_slot_start;
  logic             w_slot_last;
  logic             w_idx_last;
  logic             w_frame_start;

  assign w_slot_start  = (r_slot_cnt == '0);
  assign w_slot_last   = (r_slot_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_idx_last    = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_frame_start = w_slot_start && (r_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt <= '0;
      r_idx      <= '0;
    end else if (w_slot_last) begin
      r_slot_cnt <= '0;
      r_idx      <= w_idx_last ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_slot_cnt <= r_slot_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Blink phase
  // ---------------------------------------------------------------------------
  logic w_blink_phase;

  seg_blink_div #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_phase (w_blink_phase)
  );

  // ---------------------------------------------------------------------------
  // Lit-window length, latched per slot so a brightness change mid-slot
  // cannot stretch or cut the current digit.
  // ---------------------------------------------------------------------------
  logic [LEN_W-1:0] r_on_len;
  logic [31:0]      w_on_prod;
  logic [31:0]      w_on_shift;

  // Multiply before shifting so the fraction is not lost; the shift truncates.
  assign w_on_prod  = ON_SPAN * (32'(bus.i_dim) + 32'd1);
  assign w_on_shift = w_on_prod >> DIM_BITS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on_len <= '0;
    end else if (w_slot_start) begin
      r_on_len <= LEN_W'(w_on_shift);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-coherent shadow of digit data and masks
  // ---------------------------------------------------------------------------
  digit_cfg_t [NUM_DIGITS-1:0] w_capture;
  digit_cfg_t [NUM_DIGITS-1:0] r_shadow;
  logic       [NUM_DIGITS-1:0] w_enb_sel;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign w_capture[gi] = '{
      seg:   bus.i_digit_seg[7*gi +: 7],
      dp:    bus.i_dp[gi],
      blank: bus.i_blank_mask[gi],
      blink: bus.i_blink_mask[gi]
    };
    // Enable pattern for "digit r_idx lit": only the selected bit pulls low.
    assign w_enb_sel[gi] = (r_idx == IDX_W'(gi)) ? 1'b0 : ENB_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_frame_start) begin
      r_shadow <= w_capture;
    end
  end

  // ---------------------------------------------------------------------------
  // Lit decision. The dead time (>= 2 cycles) guarantees r_on_len and
  // r_shadow have been refreshed before any lit cycle of the slot.
  // ---------------------------------------------------------------------------
  digit_cfg_t  w_cur;
  logic [31:0] w_slot_ext;
  logic        w_in_window;
  logic        w_lit;

  assign w_cur       = r_shadow[r_idx];
  assign w_slot_ext  = 32'(r_slot_cnt);
  assign w_in_window = (w_slot_ext >= BLANK_U) &&
                       (w_slot_ext < (BLANK_U + 32'(r_on_len)));
  assign w_lit       = w_in_window && !w_cur.blank &&
                       !(w_cur.blink && !w_blink_phase);

  // ---------------------------------------------------------------------------
  // Registered pin drive
  // ---------------------------------------------------------------------------
  logic [6:0]            r_seg;
  logic                  r_seg_dp;
  logic [NUM_DIGITS-1:0] r_seg_enb;
  logic [IDX_W-1:0]      r_digit_idx;
  logic                  r_frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg         <= SEG_OFF;
      r_seg_dp      <= 1'b0;
      r_seg_enb     <= {NUM_DIGITS{ENB_OFF}};
      r_digit_idx   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= w_lit ? w_cur.seg : SEG_OFF;
      r_seg_dp      <= w_lit ? w_cur.dp  : 1'b0;
      r_seg_enb     <= w_lit ? w_enb_sel : {NUM_DIGITS{ENB_OFF}};
      r_digit_idx   <= r_idx;
      r_frame_start <= w_frame_start;
    end
  end

  assign bus.o_seg         = r_seg;
  assign bus.o_seg_dp      = r_seg_dp;
  assign bus.o_seg_enb     = r_seg_enb;
  assign bus.o_digit_idx   = r_digit_idx;
  assign bus.o_frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_drv.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_drv
// Directed bench for seg_scan_drv with 4 digits, 16-cycle slots, 2 dead
// cycles, 2-bit dimming and a 64-cycle blink half-period (one frame).
// Expected pin values are derived from the cycle count since reset release
// and from the inputs the bench applied at each slot/frame boundary.
// -----------------------------------------------------------------------------
module tb_seg_scan_drv;
  import seg_scan_drv_pkg::*;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int BC = 2;
  localparam int DB = 2;
  localparam int BD = 64;
  localparam int FRAME = ND * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_drv_if #(.NUM_DIGITS(ND), .DIM_BITS(DB)) bus ();

  seg_scan_drv #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC),
    .BLINK_DIV  (BD),
    .DIM_BITS   (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n        = 0;   // edges since reset release

  // Expectations captured at slot / frame boundaries
  int         e_on;
  logic [27:0] e_seg;
  logic [3:0]  e_dp, e_blank, e_blink;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, n, obs, exp);
  endtask

  task automatic chk_reset();
    chk("rst_enb",  32'(bus.o_seg_enb), 32'hf);
    chk("rst_seg",  32'(bus.o_seg), 32'h0);
    chk("rst_dp",   32'(bus.o_seg_dp), 32'h0);
    chk("rst_fs",   32'(bus.o_frame_start), 32'h0);
    chk("rst_idx",  32'(bus.o_digit_idx), 32'h0);
  endtask

  task automatic hold_reset(input int cyc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset();
    repeat (cyc) begin
      @(negedge clk);
      chk_reset();
    end
    rst_n = 1'b1;
    n = 0;
  endtask

  // One clock: capture what the DUT should latch this edge, then check the
  // registered outputs, which describe the counter state before the edge.
  task automatic step();
    int s, slot, k;
    bit vis, lit;
    logic [3:0] x_enb;
    logic [6:0] x_seg;
    logic       x_dp;
    if (n % SD == 0) e_on = ((SD - BC) * (int'(bus.i_dim) + 1)) >> DB;
    if (n % FRAME == 0) begin
      e_seg   = bus.i_digit_seg;
      e_dp    = bus.i_dp;
      e_blank = bus.i_blank_mask;
      e_blink = bus.i_blink_mask;
    end
    @(posedge clk);
    @(negedge clk);
    n++;
    s    = n - 1;
    slot = s % SD;
    k    = (s / SD) % ND;
    vis  = ((s / BD) % 2) == 0;
    lit  = (slot >= BC) && (slot < BC + e_on) && !e_blank[k] && !(e_blink[k] && !vis);
    x_enb = lit ? ~(4'b0001 << k) : 4'hf;
    x_seg = lit ? e_seg[7*k +: 7] : 7'h0;
    x_dp  = lit ? e_dp[k] : 1'b0;
    chk("enb",    32'(bus.o_seg_enb), 32'(x_enb));
    chk("seg",    32'(bus.o_seg), 32'(x_seg));
    chk("dp",     32'(bus.o_seg_dp), 32'(x_dp));
    chk("idx",    32'(bus.o_digit_idx), 32'(k));
    chk("fs",     32'(bus.o_frame_start), (s % FRAME == 0) ? 32'd1 : 32'd0);
    chk("onehot", ($countones(~bus.o_seg_enb) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic run(input int cyc);
    for (int i = 0; i < cyc; i++) step();
  endtask

  initial begin
    bus.i_digit_seg  = {7'd4, 7'd3, 7'd2, 7'd1};
    bus.i_dp         = 4'b1010;
    bus.i_blank_mask = 4'b0000;
    bus.i_blink_mask = 4'b0000;
    bus.i_dim        = 2'd3;
    e_on = 0; e_seg = '0; e_dp = '0; e_blank = '0; e_blink = '0;

    // Reset, then reset again in the middle of a lit slot, then full scan
    $display("test reset/scan order");
    hold_reset(3);
    run(37);
    hold_reset(2);
    run(130);

    // Dimming, with a brightness change partway through slot 1
    $display("test dimming");
    bus.i_dim = 2'd0;
    hold_reset(2);
    run(21);
    bus.i_dim = 2'd3;
    run(60);

    // Blinking digit 2 over four frames
    $display("test blink");
    bus.i_blink_mask = 4'b0100;
    hold_reset(2);
    run(256);

    // Blanked digit 1
    $display("test blank");
    bus.i_blink_mask = 4'b0000;
    bus.i_blank_mask = 4'b0010;
    hold_reset(2);
    run(64);

    // Data changed while digit 1 is scanned: visible only from next frame
    $display("test tearing");
    bus.i_blank_mask = 4'b0000;
    hold_reset(2);
    run(20);
    bus.i_digit_seg = {7'h7f, 7'h55, 7'h2a, 7'h11};
    bus.i_dp        = 4'b0101;
    run(130);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_drv.md
Name: seg_scan_drv

Overview:
Parametrised multiplexed seven-segment scanner. It is the next-generation replacement for the fixed 6-digit display driver and sits between the digit decoders and the FND pins. It runs NUM_DIGITS digits from one system clock using synchronous count enables, with no derived clocks. Added features over the fixed driver: inter-digit dead time, per-digit blanking and blinking, PWM dimming, and frame-coherent input capture.

Parameters:
- NUM_DIGITS, 6: number of digits scanned (2..16).
- SCAN_DIV, 5000: clk cycles per digit slot.
- BLANK_CYC, 50: dead-time cycles at the start of each slot. Legal range 2..SCAN_DIV-2^DIM_BITS.
- BLINK_DIV, 25000000: clk cycles per blink half-period.
- DIM_BITS, 3: width of the brightness input.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_digit_seg  in  7*NUM_DIGITS  digit k segments at [7k+6:7k], {a..g}, a is MSB, active-high
- i_dp  in  NUM_DIGITS  decimal point per digit, active-high
- i_blank_mask  in  NUM_DIGITS  1 = digit permanently dark
- i_blink_mask  in  NUM_DIGITS  1 = digit blinks
- i_dim  in  DIM_BITS  brightness; 0 = dimmest, all-ones = full
- o_seg  out  7  segment drive, active-high
- o_seg_dp  out  1  decimal-point drive
- o_seg_enb  out  NUM_DIGITS  common enables, active-low, at most one bit low
- o_digit_idx  out  clog2(NUM_DIGITS)  digit currently scanned
- o_frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - o_seg=0, o_seg_dp=0, o_seg_enb=all 1, o_digit_idx=0, o_frame_start=0.
  - slot_cnt=0, blink_cnt=0, blink_phase=1 (visible), shadow registers=0, on_len=0.
- slot_cnt counts 0..SCAN_DIV-1 every clk. On wrap, idx advances (NUM_DIGITS-1 wraps to 0).
- Frame start is the state slot_cnt==0 && idx==0.
  - That cycle's edge loads the shadow registers from i_digit_seg, i_dp, i_blank_mask and i_blink_mask.
  - Inputs changing mid-frame have no visible effect until the next frame.
- Slot start is slot_cnt==0. That edge loads on_len = ((SCAN_DIV-BLANK_CYC)*(i_dim+1)) >> DIM_BITS, using full-width unsigned arithmetic with the multiply evaluated before the shift, truncated toward zero.
- Digit lit condition:
  - BLANK_CYC <= slot_cnt < BLANK_CYC+on_len, and
  - shadow_blank[idx]==0, and
  - !(shadow_blink[idx] && blink_phase==0).
- Outputs are registered, with 1-cycle latency from the counter state:
  - Lit: o_seg_enb has bit idx low, o_seg=shadow seg[idx], o_seg_dp=shadow dp[idx].
  - Not lit: enb all 1, seg 0, dp 0.
  - o_digit_idx always equals idx.
  - o_frame_start=1 for exactly the cycle after the frame-start state.
- blink_cnt counts 0..BLINK_DIV-1 free-running. blink_phase toggles on wrap. The blink counter is not frame-aligned.
- Simultaneous events: frame start coincides with slot start. Both loads occur on the same edge.
- Reset mid-slot: everything returns to reset values immediately. Scanning restarts at digit 0, and the first o_frame_start follows the first post-reset edge.
- Because BLANK_CYC>=2, the shadow registers and on_len are always valid before the first lit cycle.

Decomposition:
- Shared package holds:
  - default parameter constants (SCAN_DIV, BLINK_DIV, DIM_BITS);
  - a clog2 function;
  - the SEG_OFF constant (7'b0) and ENB_OFF semantics.
- One sub-module, seg_blink_div: a free-running modulo-BLINK_DIV counter with a phase toggle output, reused later for setup-mode digit flashing in the clock controller.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=16, BLANK_CYC=2, DIM_BITS=2, BLINK_DIV=64. All tests check "at most one o_seg_enb bit low" every cycle.
1. Reset: hold rst_n=0, then release mid-run.
   - During reset: enb=4'b1111, seg=0, frame_start=0.
   - After release: frame_start high one cycle after the first edge, then every 64 cycles.
2. Scan order: i_dim=3, masks 0, digit k seg=7'(k+1).
   - Per slot: 2 cycles enb=1111, then 14 cycles with enb bit k low.
   - Sequence 1110, 1101, 1011, 0111; o_seg=k+1 while lit.
3. Dimming: i_dim=0, so on_len=(14*1)>>2=3.
   - Each digit lit exactly 3 cycles per 16-cycle slot.
   - i_dim changed mid-slot takes effect only from the next slot.
4. Blink: i_blink_mask=4'b0100.
   - Digit 2 lit in slots during blink_cnt cycles 0..63 and dark during cycles 64..127 after reset.
   - Digits 0, 1 and 3 unaffected.
5. Blank: i_blank_mask=4'b0010. Bit 1 of enb is never low; o_seg and o_seg_dp stay 0 during slot 1.
6. Tearing: change i_digit_seg while idx=1.
   - Digits 2 and 3 still show the old values in that frame.
   - New values appear from the next o_frame_start.
